// File: rtl/dtcm_resp_pkg.sv
// Shared DTCM responder constants: bus widths, depth, load-info one-hot bit positions and FSM states.
package dtcm_resp_pkg;

    localparam int ZCRV_XLEN       = 32;
    localparam int ZCRV_ADDR_SIZE  = 32;
    localparam int ZCRV_DTCM_DEPTH = 4096;

    // One-hot load type positions, shared with the LSU
    localparam int ZCRV_LI_LB  = 4;
    localparam int ZCRV_LI_LH  = 3;
    localparam int ZCRV_LI_LW  = 2;
    localparam int ZCRV_LI_LBU = 1;
    localparam int ZCRV_LI_LHU = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/dtcm_resp_if.sv
// LSU <-> DTCM request/response channel; master is the LSU, slave is the DTCM responder.
interface dtcm_resp_if
    import dtcm_resp_pkg::*;
();

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_load;
    logic                      req_store;
    logic [ZCRV_ADDR_SIZE-1:0] req_addr;
    logic [ZCRV_XLEN-1:0]      req_wdata;
    logic [3:0]                req_mask;
    logic [4:0]                req_load_info;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ZCRV_XLEN-1:0]      rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_load, req_store, req_addr, req_wdata, req_mask, req_load_info,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_load, req_store, req_addr, req_wdata, req_mask, req_load_info,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dtcm_sram.sv
// Single-port synchronous DTCM RAM with per-byte write enables; drop-in point for a foundry macro.
module dtcm_sram #(
    parameter  int DEPTH_WORDS = 4096,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // rdata holds its value when re is low, so it doubles as the raw-word register
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dtcm_resp.sv
// DTCM responder: aligns store bytes, extends load data and returns one registered response per accepted request.
module dtcm_resp
    import dtcm_resp_pkg::*;
#(
    parameter  int DEPTH_WORDS = ZCRV_DTCM_DEPTH,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    dtcm_resp_if.slave  bus
);

    function automatic logic signed [ZCRV_XLEN-1:0] extract(
        input logic [31:0] raw,
        input logic [1:0]  off,
        input logic [4:0]  info
    );
        logic        [31:0] shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = raw >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? raw[31:16] : raw[15:0];
        if (info[ZCRV_LI_LB])       extract = {{24{b[7]}}, b};
        else if (info[ZCRV_LI_LH])  extract = {{16{h[15]}}, h};
        else if (info[ZCRV_LI_LBU]) extract = {24'd0, b};
        else if (info[ZCRV_LI_LHU]) extract = {16'd0, h};
        else if (info[ZCRV_LI_LW])  extract = raw;
        else                        extract = '0;
    endfunction

    // Stage p0: request decode, fault detection and lane alignment
    logic          accept_p0;
    logic [AW-1:0] idx_p0;
    logic [1:0]    off_p0;
    logic          err_p0;
    logic [7:0]    be_wide_p0;
    logic [31:0]   wdata_p0;
    logic          we_p0;
    logic          re_p0;
    logic          unused_ok;

    assign accept_p0  = bus.req_valid & bus.req_ready;
    assign idx_p0     = bus.req_addr[AW+1:2];
    assign off_p0     = bus.req_addr[1:0];
    assign err_p0     = (|bus.req_addr[ZCRV_ADDR_SIZE-2:AW+2])
                      | (bus.req_load & bus.req_store)
                      | ~(bus.req_load | bus.req_store);
    assign be_wide_p0 = {4'b0000, ~bus.req_mask} << off_p0;
    assign wdata_p0   = bus.req_wdata << {off_p0, 3'b000};
    assign we_p0      = accept_p0 & bus.req_store & ~err_p0 & ~rst;
    assign re_p0      = accept_p0 & bus.req_load  & ~err_p0 & ~rst;
    // Top address bit is the ITCM/DTCM select and carries no information here
    assign unused_ok  = ^{bus.req_addr[ZCRV_ADDR_SIZE-1], be_wide_p0[7:4]};

    // Stage p1: raw word from the array plus the registered request attributes
    logic [31:0] raw_p1;
    logic [1:0]  off_p1;
    logic [4:0]  info_p1;
    logic        err_p1;
    logic        load_p1;
    state_e      state;

    dtcm_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (clk),
        .re    (re_p0),
        .we    (we_p0),
        .be    (be_wide_p0[3:0]),
        .addr  (idx_p0),
        .wdata (wdata_p0),
        .rdata (raw_p1)
    );

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            off_p1  <= off_p0;
            info_p1 <= bus.req_load_info;
        end
        if (rst) begin
            state   <= IDLE;
            err_p1  <= 1'b0;
            load_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (accept_p0) state <= RESP;
                RESP:    if (bus.rsp_ready && !accept_p0) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (accept_p0) begin
                err_p1  <= err_p0;
                load_p1 <= bus.req_load & ~err_p0;
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.req_ready = ~bus.rsp_valid | bus.rsp_ready;
    assign bus.rsp_err   = bus.rsp_valid & err_p1;
    assign bus.rsp_rdata = (bus.rsp_valid && load_p1) ? extract(raw_p1, off_p1, info_p1) : '0;

endmodule

// File: tb/tb_dtcm_resp.sv
// Directed bench for dtcm_resp: word/byte/half access, backpressure, faults and reset behaviour.
module tb_dtcm_resp;
    import dtcm_resp_pkg::*;

    localparam logic [4:0] LI_LB  = 5'b10000;
    localparam logic [4:0] LI_LH  = 5'b01000;
    localparam logic [4:0] LI_LW  = 5'b00100;
    localparam logic [4:0] LI_LBU = 5'b00010;
    localparam logic [4:0] LI_LHU = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dtcm_resp_if bus();

    dtcm_resp u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] mask, input logic [4:0] info);
        bus.req_valid     = 1'b1;
        bus.req_load      = ld;
        bus.req_store     = st;
        bus.req_addr      = addr;
        bus.req_wdata     = wd;
        bus.req_mask      = mask;
        bus.req_load_info = info;
    endtask

    task automatic idle_req();
        bus.req_valid = 1'b0;
        bus.req_load  = 1'b0;
        bus.req_store = 1'b0;
    endtask

    // One request with rsp_ready held high; response checked one cycle after the accept edge
    task automatic xact(input string tag, input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] mask, input logic [4:0] info,
                        input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        drive(ld, st, addr, wd, mask, info);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 idle_req();
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, ".rdata"}, bus.rsp_rdata, exp_d);
        chk({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_e));
    endtask

    initial begin
        idle_req();
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.req_mask      = '0;
        bus.req_load_info = '0;
        bus.rsp_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset.rdata", bus.rsp_rdata, 32'd0);
        chk("reset.err", 32'(bus.rsp_err), 32'd0);
        chk("reset.req_ready", 32'(bus.req_ready), 32'd1);

        xact("sw10", 0, 1, 32'h10, 32'hDEAD_BEEF, 4'b0000, 5'b0, 32'h0, 0);
        xact("lw10", 1, 0, 32'h10, 32'h0, 4'b0000, LI_LW, 32'hDEAD_BEEF, 0);

        xact("sw10b", 0, 1, 32'h10, 32'h1122_3344, 4'b0000, 5'b0, 32'h0, 0);
        xact("sb12", 0, 1, 32'h12, 32'h0000_00AA, 4'b1110, 5'b0, 32'h0, 0);
        xact("lw10b", 1, 0, 32'h10, 32'h0, 4'b0000, LI_LW, 32'h11AA_3344, 0);
        xact("lb12", 1, 0, 32'h12, 32'h0, 4'b1110, LI_LB, 32'hFFFF_FFAA, 0);
        xact("lbu12", 1, 0, 32'h12, 32'h0, 4'b1110, LI_LBU, 32'h0000_00AA, 0);
        xact("lb13", 1, 0, 32'h13, 32'h0, 4'b1110, LI_LB, 32'h0000_0011, 0);

        xact("sw20", 0, 1, 32'h20, 32'h5566_7788, 4'b0000, 5'b0, 32'h0, 0);
        xact("sh22", 0, 1, 32'h22, 32'h0000_8001, 4'b1100, 5'b0, 32'h0, 0);
        xact("lw20", 1, 0, 32'h20, 32'h0, 4'b0000, LI_LW, 32'h8001_7788, 0);
        xact("lh22", 1, 0, 32'h22, 32'h0, 4'b1100, LI_LH, 32'hFFFF_8001, 0);
        xact("lhu22", 1, 0, 32'h22, 32'h0, 4'b1100, LI_LHU, 32'h0000_8001, 0);
        xact("lh20", 1, 0, 32'h20, 32'h0, 4'b1100, LI_LH, 32'h0000_7788, 0);
        xact("lbu23", 1, 0, 32'h23, 32'h0, 4'b1110, LI_LBU, 32'h0000_0080, 0);
        xact("lb20", 1, 0, 32'h20, 32'h0, 4'b1110, LI_LB, 32'hFFFF_FF88, 0);

        // Backpressure: two back-to-back loads with the consumer stalled for 3 cycles
        xact("sw14", 0, 1, 32'h14, 32'hCAFE_F00D, 4'b0000, 5'b0, 32'h0, 0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive(1, 0, 32'h10, 32'h0, 4'b0000, LI_LW);
        @(posedge clk);
        #1 drive(1, 0, 32'h14, 32'h0, 4'b0000, LI_LW);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.hold.valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp.hold.rdata", bus.rsp_rdata, 32'h11AA_3344);
            chk("bp.hold.req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1 chk("bp.release.req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 idle_req();
        @(negedge clk);
        chk("bp.second.valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp.second.rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        chk("bp.drain.valid", 32'(bus.rsp_valid), 32'd0);

        // Faults
        xact("sw0", 0, 1, 32'h0, 32'hA5A5_A5A5, 4'b0000, 5'b0, 32'h0, 0);
        xact("lw.oor", 1, 0, 32'h0010_0000, 32'h0, 4'b0000, LI_LW, 32'h0, 1);
        xact("sw.oor", 0, 1, 32'h0010_0000, 32'h1234_5678, 4'b0000, 5'b0, 32'h0, 1);
        xact("ldst.both", 1, 1, 32'h0, 32'h1234_5678, 4'b0000, LI_LW, 32'h0, 1);
        xact("ldst.none", 0, 0, 32'h0, 32'h0, 4'b0000, LI_LW, 32'h0, 1);
        xact("lw0", 1, 0, 32'h0, 32'h0, 4'b0000, LI_LW, 32'hA5A5_A5A5, 0);
        xact("lw.sel", 1, 0, 32'h8000_0010, 32'h0, 4'b0000, LI_LW, 32'h11AA_3344, 0);

        // Reset with a stalled response and a store presented across two reset edges
        xact("sw30", 0, 1, 32'h30, 32'h0BAD_F00D, 4'b0000, 5'b0, 32'h0, 0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive(1, 0, 32'h30, 32'h0, 4'b0000, LI_LW);
        @(posedge clk);
        #1 drive(0, 1, 32'h30, 32'hFFFF_FFFF, 4'b0000, 5'b0);
        @(negedge clk);
        chk("rst.pre.valid", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.drop.valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.drop.rdata", bus.rsp_rdata, 32'd0);
        chk("rst.drop.err", 32'(bus.rsp_err), 32'd0);
        chk("rst.drop.req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("rst.idle.valid", 32'(bus.rsp_valid), 32'd0);
        idle_req();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        xact("lw30", 1, 0, 32'h30, 32'h0, 4'b0000, LI_LW, 32'h0BAD_F00D, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
